// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. It holds a PC generator that
// drives a synchronous (1-cycle latency) imem and a DEPTH-entry queue of
// {insn, pc} that feeds decode.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   address_imem        imem read address (the fetch_pc register)
//   q_imem              imem data, valid the cycle after its address
//   redirect_valid/pc   backend redirect: flush everything and refetch at pc
//   dec_valid/dec_ready decode handshake on the queue head
//   dec_insn/pc/pc_inc  head entry (all zero when dec_valid is low)
//   occupancy           number of entries currently held
//
// Handshake: the head transfers on a rising edge where dec_valid and
// dec_ready are both high. dec_valid never depends on dec_ready, and the
// head stays stable until it transfers or a redirect/reset flushes it.
module fetch_queue #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    INSN_WIDTH     = 32,
  parameter int                    DEPTH          = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter bit                    PREDECODE_JUMP = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic [ADDR_WIDTH-1:0]   address_imem,
  input  logic [INSN_WIDTH-1:0]   q_imem,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    dec_valid,
  input  logic                    dec_ready,
  output logic [INSN_WIDTH-1:0]   dec_insn,
  output logic [ADDR_WIDTH-1:0]   dec_pc,
  output logic [ADDR_WIDTH-1:0]   dec_pc_inc,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] pending_pc;
  logic                  pending;
  logic [CW-1:0]         count;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;

  logic [INSN_WIDTH-1:0] insn_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

  logic                  pop;
  logic                  push;
  logic                  is_jump;
  logic                  jump_hit;
  logic                  issue;
  logic [4:0]            opcode;
  logic [CW:0]           credit_level;
  logic [ADDR_WIDTH-1:0] jump_target;

  assign opcode      = q_imem[INSN_WIDTH-1 -: 5];
  assign is_jump     = (opcode == 5'b00001) || (opcode == 5'b00011);
  assign jump_hit    = PREDECODE_JUMP && pending && !redirect_valid && is_jump;
  assign jump_target = ADDR_WIDTH'(q_imem[26:0]);

  // A response in flight is captured unless a redirect discards it.
  assign push = pending && !redirect_valid;
  assign pop  = dec_valid && dec_ready;

  // Credit rule: entries held after this edge plus the response already in
  // flight must leave room for the one we are about to request.
  assign credit_level = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, pending};
  assign issue = !redirect_valid && !jump_hit && (credit_level < (CW+1)'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= '0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      pending  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (jump_hit) begin
        // The jump itself is queued; the slot that would have fetched the
        // fall-through address becomes a one-cycle bubble.
        fetch_pc <= jump_target;
        pending  <= 1'b0;
      end else if (issue) begin
        pending    <= 1'b1;
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + ADDR_WIDTH'(1);
      end else begin
        pending <= 1'b0;
      end
    end
  end

  // Entry storage needs no reset: it is only visible through dec_valid.
  always_ff @(posedge clock) begin
    if (push) begin
      insn_mem[wr_ptr] <= q_imem;
      pc_mem[wr_ptr]   <= pending_pc;
    end
  end

  assign address_imem = fetch_pc;
  assign occupancy    = count;
  assign dec_valid    = (count != '0);
  assign dec_insn     = dec_valid ? insn_mem[rd_ptr] : '0;
  assign dec_pc       = dec_valid ? pc_mem[rd_ptr] : '0;
  assign dec_pc_inc   = dec_valid ? (pc_mem[rd_ptr] + ADDR_WIDTH'(1)) : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios followed by randomized
// ready/redirect traffic, all checked every cycle against a queue-based
// behavioural model of the fetch front end.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [31:0] address_imem;
  logic [31:0] q_imem;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_insn;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_inc;
  logic [2:0]  occupancy;

  fetch_queue #(
    .ADDR_WIDTH(32), .INSN_WIDTH(32), .DEPTH(DEPTH),
    .RESET_PC(32'h0), .PREDECODE_JUMP(1'b1)
  ) dut (
    .clock(clock), .reset(reset),
    .address_imem(address_imem), .q_imem(q_imem),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_insn(dec_insn), .dec_pc(dec_pc), .dec_pc_inc(dec_pc_inc),
    .occupancy(occupancy)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] m_pc;
  logic        m_pending;
  logic [31:0] m_ppc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // imem contents: i+100 except a few jumps (j = 00001, jal = 00011).
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a + 32'd100;
    if (a == 32'd3)    w = {5'b00001, 27'h20};
    if (a == 32'h2A)   w = {5'b00011, 27'h60};
    if (a == 32'h65)   w = {5'b00001, 27'h05};
    return w;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc      = 32'h0;
    m_pending = 1'b0;
    m_ppc     = 32'h0;
  endtask

  task automatic check_outputs();
    logic [31:0] e_insn, e_pc, e_inc;
    e_insn = 32'h0; e_pc = 32'h0; e_inc = 32'h0;
    if (exp_q.size() != 0) begin
      e_insn = exp_q[0].insn;
      e_pc   = exp_q[0].pc;
      e_inc  = exp_q[0].pc + 32'd1;
    end
    check("dec_valid",    64'(dec_valid),    64'(exp_q.size() != 0));
    check("dec_insn",     64'(dec_insn),     64'(e_insn));
    check("dec_pc",       64'(dec_pc),       64'(e_pc));
    check("dec_pc_inc",   64'(dec_pc_inc),   64'(e_inc));
    check("occupancy",    64'(occupancy),    64'(exp_q.size()));
    check("address_imem", 64'(address_imem), 64'(m_pc));
  endtask

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    logic [31:0] resp;
    logic [31:0] addr;
    bit          pop, jhit, iss;
    dec_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    check_outputs();
    pop  = (exp_q.size() != 0) && rdy;
    resp = imem_word(m_ppc);
    jhit = m_pending && !rv && (resp[31:27] == 5'b00001 || resp[31:27] == 5'b00011);
    iss  = !rv && !jhit && ((int'(exp_q.size()) - int'(pop) + int'(m_pending)) < DEPTH);
    if (rv) begin
      exp_q.delete();
      m_pending = 1'b0;
      m_pc      = rpc;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (m_pending) exp_q.push_back('{insn: resp, pc: m_ppc});
      if (jhit) begin
        m_pc      = {5'b0, resp[26:0]};
        m_pending = 1'b0;
      end else if (iss) begin
        m_ppc     = m_pc;
        m_pc      = m_pc + 32'd1;
        m_pending = 1'b1;
      end else begin
        m_pending = 1'b0;
      end
    end
    addr = address_imem;
    @(posedge clock);
    #1 q_imem = imem_word(addr);
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(dec_valid),    64'h0);
    check({tag, "_insn"},  64'(dec_insn),     64'h0);
    check({tag, "_pc"},    64'(dec_pc),       64'h0);
    check({tag, "_inc"},   64'(dec_pc_inc),   64'h0);
    check({tag, "_occ"},   64'(occupancy),    64'h0);
    check({tag, "_addr"},  64'(address_imem), 64'h0);
  endtask

  initial begin
    int guard;
    reset          = 1'b1;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    q_imem         = 32'h0;
    model_reset();
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Streaming from reset, including the jump at address 3.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0);

    // Backpressure: queue saturates at DEPTH, then drains in order.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'h0);

    // Redirect while three entries are held and a response is in flight.
    step(1'b1, 1'b1, 32'h10);
    guard = 0;
    while (!(exp_q.size() == 3 && m_pending) && guard < 20) begin
      step(1'b0, 1'b0, 32'h0);
      guard++;
    end
    check("occ3_pending_reached", 64'(guard < 20), 64'h1);
    step(1'b0, 1'b1, 32'h40);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

    // Redirect in the same cycle the jump response arrives.
    step(1'b1, 1'b1, 32'h0);
    guard = 0;
    while (!(m_pending && m_ppc == 32'd3) && guard < 20) begin
      step(1'b1, 1'b0, 32'h0);
      guard++;
    end
    check("jump_pending_reached", 64'(guard < 20), 64'h1);
    step(1'b1, 1'b1, 32'h80);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

    // Asynchronous reset mid-stream with two entries held.
    guard = 0;
    while (exp_q.size() != 2 && guard < 20) begin
      step(1'b0, 1'b0, 32'h0);
      guard++;
    end
    check("occ2_reached", 64'(guard < 20), 64'h1);
    #1 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

    // PC wrap at the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);

    // Randomized ready and redirect traffic.
    for (int i = 0; i < 1500; i++) begin
      bit          rdy, rv;
      logic [31:0] rpc;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 39) == 0);
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 127));
      step(rdy, rv, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
